// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - program-download port between loader and fetch_unit
interface fetch_unit_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;

  modport master (output load_valid, output load_addr, output load_data, input load_ready);
  modport slave  (input load_valid, input load_addr, input load_data, output load_ready);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction memory, program counter and zero flag with run/halt sequencing
module fetch_unit #(
  parameter int AW    = 10,
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  fetch_unit_if.slave      load,
  input  logic             start,
  input  logic             s_inc,
  input  logic             wez,
  input  logic             alu_zero,
  output logic [5:0]       opcode,
  output logic [DW-1:0]    instr,
  output logic             zero,
  output logic [AW-1:0]    pc,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Memory contents survive reset so a downloaded program can be rerun.
  logic [DW-1:0]    mem_q [0:(1<<AW)-1];
  logic             mem_we;
  logic [DW-1:0]    mem_rd;
  logic [AW-1:0]    target;

  // Decode outputs; outside RUN the control unit sees a harmless self-jump.
  always_comb begin
    mem_rd          = mem_q[pc_q];
    running         = (state_q == ST_RUN);
    halted          = (state_q == ST_HALT);
    load.load_ready = (state_q != ST_RUN);
    instr           = '0;
    if (state_q == ST_RUN) begin
      instr = mem_rd;
    end else begin
      instr[DW-1 -: 6] = 6'b111111;
      instr[AW-1:0]    = pc_q;
    end
    opcode = instr[DW-1 -: 6];
    target = instr[AW-1:0];
    mem_we = load.load_valid && (state_q != ST_RUN) && !reset;
  end

  // Next-state logic: start (re)initialises, RUN steps the PC, a self-jump halts.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          zero_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (wez) begin
          zero_d = alu_zero;
        end
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!s_inc && (target == pc_q)) begin
          state_d = ST_HALT;
        end else if (s_inc) begin
          pc_d = pc_q + AW'(1);
        end else begin
          pc_d = target;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  // Program download write port; gated off in RUN and during reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load.load_addr] <= load.load_data;
    end
  end

  assign zero        = zero_q;
  assign pc          = pc_q;
  assign cycle_count = cnt_q;

endmodule
